// File: rtl/hilo_unit_pkg.sv
// -----------------------------------------------------------------------------
// hilo_unit_pkg
//   Shared definitions for the HI/LO register unit: the 3-bit op encodings
//   driven by the EX-stage controller and the divide-sequencing FSM states.
//   Encodings 5..7 are unused and behave as HILO_OP_NONE.
// -----------------------------------------------------------------------------
package hilo_unit_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] HILO_OP_NONE = 3'd0;
    localparam logic [OP_W-1:0] HILO_OP_MUL  = 3'd1;  // MULT / MULTU
    localparam logic [OP_W-1:0] HILO_OP_DIV  = 3'd2;  // DIV / DIVU
    localparam logic [OP_W-1:0] HILO_OP_MTHI = 3'd3;
    localparam logic [OP_W-1:0] HILO_OP_MTLO = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DIV_WAIT   = 2'd1,
        ST_DIV_COMMIT = 2'd2
    } hilo_state_t;

endpackage

// File: rtl/hilo_unit.sv
// -----------------------------------------------------------------------------
// hilo_unit
//   Architectural HI/LO register pair and multiply/divide sequencing control.
//   Captures the ALU's 64-bit result for MUL/DIV, performs MTHI/MTLO, and
//   holds the EX stage while the ALU's multi-cycle divider runs.
//
// Parameters
//   DIV_LATENCY  cycles from divide issue to valid quotient/remainder (1..255)
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   flush     in   exception flush, synchronous, aborts any divide
//   valid     in   EX-stage instruction valid
//   op        in   hilo_unit_pkg op encoding
//   res_lo    in   ALU low result (product low word / quotient)
//   res_hi    in   ALU high result (product high word / remainder)
//   wdata     in   rs value for MTHI/MTLO
//   hi_out    out  registered HI
//   lo_out    out  registered LO
//   stall     out  hold IF/ID/EX (combinational)
//   busy      out  sequencer not idle (decoded from state register)
//   div_done  out  one-cycle pulse in the divide commit cycle
// -----------------------------------------------------------------------------
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int DIV_LATENCY = 34
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        valid,
    input  logic [2:0]  op,
    input  logic [31:0] res_lo,
    input  logic [31:0] res_hi,
    input  logic [31:0] wdata,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        stall,
    output logic        busy,
    output logic        div_done
);

    localparam int CNT_W = $clog2(DIV_LATENCY + 1);

    // Wait cycles remaining after the first DIV_WAIT cycle; unused when the
    // divider finishes in a single cycle.
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'((DIV_LATENCY > 1) ? (DIV_LATENCY - 2) : 0);

    hilo_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic div_issue;

    // A new divide is accepted only from IDLE; the DIV still sitting in EX
    // during DIV_COMMIT is the retiring instruction, not a new one.
    assign div_issue = (state_q == ST_IDLE) && valid && (op == HILO_OP_DIV) && !flush;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned; that is what keeps this block latch-free.
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (valid) begin
                        case (op)
                            HILO_OP_DIV: begin
                                if (DIV_LATENCY > 1) begin
                                    state_d = ST_DIV_WAIT;
                                    cnt_d   = CNT_INIT;
                                end else begin
                                    state_d = ST_DIV_COMMIT;
                                end
                            end
                            HILO_OP_MUL: begin
                                hi_d = res_hi;
                                lo_d = res_lo;
                            end
                            HILO_OP_MTHI: hi_d = wdata;
                            HILO_OP_MTLO: lo_d = wdata;
                            default: ;
                        endcase
                    end
                end
                ST_DIV_WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = ST_DIV_COMMIT;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_DIV_COMMIT: begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its inputs as they were before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;
    assign busy   = (state_q != ST_IDLE);

    // A flushed commit writes nothing, so it does not report completion.
    assign div_done = (state_q == ST_DIV_COMMIT) && !flush;

    // Gated by rst so a DIV presented during reset cannot raise stall.
    assign stall = rst && !flush &&
                   (div_issue || (state_q == ST_DIV_WAIT));

endmodule

// File: tb/tb_hilo_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_unit
//   Directed bench for hilo_unit. Two instances share clock and reset: one
//   with the default divide latency of 34, one with a latency of 1.
//   Inputs are driven 1 time unit after the rising edge; outputs are sampled
//   1 time unit later, well clear of either clock edge.
// -----------------------------------------------------------------------------
module tb_hilo_unit;
    import hilo_unit_pkg::*;

    localparam int LAT = 34;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        flush, valid;
    logic [2:0]  op;
    logic [31:0] res_lo, res_hi, wdata;
    logic [31:0] hi_out, lo_out;
    logic        stall, busy, div_done;

    logic        flush1, valid1;
    logic [2:0]  op1;
    logic [31:0] res_lo1, res_hi1, wdata1;
    logic [31:0] hi_out1, lo_out1;
    logic        stall1, busy1, div_done1;

    int n_checks = 0;
    int n_fail   = 0;
    int stall_cnt;

    always #5 clk = ~clk;

    hilo_unit #(.DIV_LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .valid(valid), .op(op),
        .res_lo(res_lo), .res_hi(res_hi), .wdata(wdata),
        .hi_out(hi_out), .lo_out(lo_out), .stall(stall), .busy(busy),
        .div_done(div_done)
    );

    hilo_unit #(.DIV_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush1), .valid(valid1), .op(op1),
        .res_lo(res_lo1), .res_hi(res_hi1), .wdata(wdata1),
        .hi_out(hi_out1), .lo_out(lo_out1), .stall(stall1), .busy(busy1),
        .div_done(div_done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; the caller then drives the
    // inputs for that cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] lo,
                         input logic [31:0] hi, input logic [31:0] wd, input logic fl);
        valid  = v;
        op     = o;
        res_lo = lo;
        res_hi = hi;
        wdata  = wd;
        flush  = fl;
    endtask

    task automatic drive1(input logic v, input logic [2:0] o, input logic [31:0] lo,
                          input logic [31:0] hi);
        valid1  = v;
        op1     = o;
        res_lo1 = lo;
        res_hi1 = hi;
        wdata1  = '0;
        flush1  = 1'b0;
    endtask

    initial begin
        // ---------------- reset, with a DIV presented during reset --------
        drive(1'b1, HILO_OP_DIV, 32'h0, 32'h0, 32'h0, 1'b0);
        drive1(1'b0, HILO_OP_NONE, 32'h0, 32'h0);
        #12;
        check("rst_hi",    hi_out,   32'h0);
        check("rst_lo",    lo_out,   32'h0);
        check("rst_stall", stall,    32'h0);
        check("rst_busy",  busy,     32'h0);
        check("rst_done",  div_done, 32'h0);
        drive(1'b0, HILO_OP_NONE, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- MUL -------------------------------------------
        cyc();
        drive(1'b1, HILO_OP_MUL, 32'h8000_0000, 32'h0000_0001, 32'h0, 1'b0);
        settle();
        check("mul_stall", stall, 32'h0);
        cyc();
        drive(1'b0, HILO_OP_NONE, 32'h0, 32'h0, 32'h0, 1'b0);
        settle();
        check("mul_hi",    hi_out, 32'h0000_0001);
        check("mul_lo",    lo_out, 32'h8000_0000);
        check("mul_stall2", stall, 32'h0);

        // ---------------- MTHI then MTLO --------------------------------
        cyc();
        drive(1'b1, HILO_OP_MTHI, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        cyc();
        drive(1'b1, HILO_OP_MTLO, 32'h0, 32'h0, 32'h1234_5678, 1'b0);
        settle();
        check("mthi_hi", hi_out, 32'hDEAD_BEEF);
        check("mthi_lo", lo_out, 32'h8000_0000);
        cyc();
        drive(1'b0, HILO_OP_NONE, 32'h0, 32'h0, 32'h0, 1'b0);
        settle();
        check("mtlo_hi", hi_out, 32'hDEAD_BEEF);
        check("mtlo_lo", lo_out, 32'h1234_5678);

        // ---------------- DIV, full latency -----------------------------
        // DIV held in EX through the commit cycle; junk results until valid.
        stall_cnt = 0;
        for (int k = 0; k <= LAT; k++) begin
            cyc();
            if (k == LAT) drive(1'b1, HILO_OP_DIV, 32'd7, 32'd3, 32'h0, 1'b0);
            else          drive(1'b1, HILO_OP_DIV, 32'h5555_5555, 32'hAAAA_AAAA, 32'h0, 1'b0);
            settle();
            check($sformatf("div_stall_c%0d", k), stall,    (k < LAT) ? 32'h1 : 32'h0);
            check($sformatf("div_done_c%0d",  k), div_done, (k == LAT) ? 32'h1 : 32'h0);
            check($sformatf("div_busy_c%0d",  k), busy,     (k >= 1) ? 32'h1 : 32'h0);
            if (stall) stall_cnt++;
        end
        check("div_hold_hi", hi_out, 32'hDEAD_BEEF);
        check("div_stall_count", stall_cnt, LAT);
        cyc();
        drive(1'b0, HILO_OP_NONE, 32'h0, 32'h0, 32'h0, 1'b0);
        settle();
        check("div_lo",      lo_out, 32'd7);
        check("div_hi",      hi_out, 32'd3);
        check("div_busy_end", busy,  32'h0);

        // ---------------- DIV flushed at cycle 10 -----------------------
        for (int k = 0; k < 10; k++) begin
            cyc();
            drive(1'b1, HILO_OP_DIV, 32'h9999_9999, 32'h9999_9999, 32'h0, 1'b0);
        end
        cyc();
        drive(1'b1, HILO_OP_DIV, 32'h9999_9999, 32'h9999_9999, 32'h0, 1'b1);
        settle();
        check("fl_stall_c10", stall, 32'h0);
        check("fl_busy_c10",  busy,  32'h1);
        cyc();
        drive(1'b0, HILO_OP_NONE, 32'h0, 32'h0, 32'h0, 1'b0);
        settle();
        check("fl_busy_c11",  busy,   32'h0);
        check("fl_stall_c11", stall,  32'h0);
        check("fl_hi",        hi_out, 32'd3);
        check("fl_lo",        lo_out, 32'd7);

        // Next DIV must stall the full latency.
        stall_cnt = 0;
        for (int k = 0; k <= LAT; k++) begin
            cyc();
            if (k == LAT) drive(1'b1, HILO_OP_DIV, 32'h0000_000A, 32'h0000_000B, 32'h0, 1'b0);
            else          drive(1'b1, HILO_OP_DIV, 32'h1111_1111, 32'h2222_2222, 32'h0, 1'b0);
            settle();
            if (stall) stall_cnt++;
        end
        check("fl2_stall_count", stall_cnt, LAT);
        check("fl2_done", div_done, 32'h1);
        cyc();
        drive(1'b0, HILO_OP_NONE, 32'h0, 32'h0, 32'h0, 1'b0);
        settle();
        check("fl2_lo", lo_out, 32'h0000_000A);
        check("fl2_hi", hi_out, 32'h0000_000B);

        // ---------------- async reset at cycle 20 of a divide -----------
        for (int k = 0; k <= 20; k++) begin
            cyc();
            drive(1'b1, HILO_OP_DIV, 32'h7777_7777, 32'h7777_7777, 32'h0, 1'b0);
        end
        settle();
        check("ar_busy_pre", busy, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_hi",    hi_out,   32'h0);
        check("ar_lo",    lo_out,   32'h0);
        check("ar_busy",  busy,     32'h0);
        check("ar_stall", stall,    32'h0);
        check("ar_done",  div_done, 32'h0);
        drive(1'b0, HILO_OP_NONE, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        cyc();
        settle();
        check("ar_post_hi",   hi_out, 32'h0);
        check("ar_post_lo",   lo_out, 32'h0);
        check("ar_post_busy", busy,   32'h0);

        // ---------------- DIV_LATENCY = 1 -------------------------------
        cyc();
        drive1(1'b1, HILO_OP_DIV, 32'hCCCC_CCCC, 32'hCCCC_CCCC);
        settle();
        check("l1_stall_c0", stall1, 32'h1);
        check("l1_busy_c0",  busy1,  32'h0);
        cyc();
        drive1(1'b1, HILO_OP_DIV, 32'h0000_0011, 32'h0000_0022);
        settle();
        check("l1_stall_c1", stall1,    32'h0);
        check("l1_done_c1",  div_done1, 32'h1);
        check("l1_busy_c1",  busy1,     32'h1);
        cyc();
        drive1(1'b1, HILO_OP_DIV, 32'hEEEE_EEEE, 32'hEEEE_EEEE);
        settle();
        check("l1_busy_c2",  busy1,     32'h0);
        check("l1_done_c2",  div_done1, 32'h0);
        check("l1_stall_c2", stall1,    32'h1);
        check("l1_lo_c2",    lo_out1,   32'h0000_0011);
        check("l1_hi_c2",    hi_out1,   32'h0000_0022);
        cyc();
        drive1(1'b1, HILO_OP_DIV, 32'h0000_0033, 32'h0000_0044);
        settle();
        check("l1_done_c3",  div_done1, 32'h1);
        check("l1_stall_c3", stall1,    32'h0);
        cyc();
        drive1(1'b0, HILO_OP_NONE, 32'h0, 32'h0);
        settle();
        check("l1_lo_c4",   lo_out1, 32'h0000_0033);
        check("l1_hi_c4",   hi_out1, 32'h0000_0044);
        check("l1_busy_c4", busy1,   32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
